// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD-card block-write scheduler.
package sdc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      START,
      XFER,
      BUSY_RISE,
      BUSY_CLR,
      GAP
   } sched_state_e;

   // The sender samples the word on sm_rd_addr this many cycles after its start strobe.
   localparam int SND_DAT_SAMPLE_LAT = 2;
   localparam int WORDS_PER_BLK_DEF  = 64;

endpackage

// File: rtl/sdc_blk_wr_sched_if.sv
// Host request, system-memory read and sender handshake signals of the block-write scheduler.
interface sdc_blk_wr_sched_if #(
   parameter int ADDR_W = 12
);
   logic              wr_req;
   logic [15:0]       blk_cnt;
   logic [ADDR_W-1:0] base_addr;
   logic              abort;
   logic [ADDR_W-1:0] sm_rd_addr;
   logic              sm_rd_en;
   logic              strt_snd_data_strb;
   logic              new_dat_strb;
   logic              dat_tf_done;
   logic              wr_busy;
   logic              sched_busy;
   logic              done_strb;
   logic [15:0]       blks_done;
   logic              err_no_busy;
   logic              err_timeout;
   logic              aborted;

   modport master (
      output wr_req, blk_cnt, base_addr, abort, new_dat_strb, dat_tf_done, wr_busy,
      input  sm_rd_addr, sm_rd_en, strt_snd_data_strb, sched_busy, done_strb,
             blks_done, err_no_busy, err_timeout, aborted
   );

   modport slave (
      input  wr_req, blk_cnt, base_addr, abort, new_dat_strb, dat_tf_done, wr_busy,
      output sm_rd_addr, sm_rd_en, strt_snd_data_strb, sched_busy, done_strb,
             blks_done, err_no_busy, err_timeout, aborted
   );
endinterface

// File: rtl/sdc_wr_busy_mon.sv
// Card write-busy monitor: busy-rise window and (with SDC_WR_BUSY_TIMEOUT_EN) busy-clear timeout.
module sdc_wr_busy_mon #(
   parameter int BUSY_RISE_WIN = 4
`ifdef SDC_WR_BUSY_TIMEOUT_EN
   , parameter logic [23:0] BUSY_TO = 24'hFFFFFF
`endif
) (
   input  logic sd_clk,
   input  logic reset,
   input  logic rise_en,
   input  logic clr_en,
   input  logic wr_busy,
   output logic busy_rose,
   output logic no_busy,
   output logic busy_cleared,
   output logic timeout
);
   logic [7:0] rise_cnt;

   always_ff @(posedge sd_clk) begin
      if (reset || !rise_en) begin
         rise_cnt <= 8'd0;
      end else if (rise_cnt != 8'(BUSY_RISE_WIN - 1)) begin
         rise_cnt <= rise_cnt + 8'd1;
      end
   end

   assign busy_rose    = rise_en && wr_busy;
   assign no_busy      = rise_en && !wr_busy && (rise_cnt == 8'(BUSY_RISE_WIN - 1));
   assign busy_cleared = clr_en && !wr_busy;

`ifdef SDC_WR_BUSY_TIMEOUT_EN
   logic [23:0] to_cnt;

   always_ff @(posedge sd_clk) begin
      if (reset || !clr_en) begin
         to_cnt <= 24'd0;
      end else if (to_cnt != BUSY_TO - 24'd1) begin
         to_cnt <= to_cnt + 24'd1;
      end
   end

   // A clear in the final cycle still wins over the timeout.
   assign timeout = clr_en && wr_busy && (to_cnt == BUSY_TO - 24'd1);
`else
   assign timeout = 1'b0;
`endif
endmodule

// File: rtl/sdc_blk_wr_sched.sv
// Multi-block write scheduler: strobes the 1-bit data sender per block, feeds it RAM addresses,
// and paces blocks on card write-busy. Optional busy-clear timeout: SDC_WR_BUSY_TIMEOUT_EN.
module sdc_blk_wr_sched
   import sdc_pkg::*;
#(
   parameter int ADDR_W        = 12,
   parameter int WORDS_PER_BLK = WORDS_PER_BLK_DEF,
   parameter int GAP_CLKS      = 8,
   parameter int BUSY_RISE_WIN = 4
`ifdef SDC_WR_BUSY_TIMEOUT_EN
   , parameter logic [23:0] BUSY_TO = 24'hFFFFFF
`endif
) (
   input logic               sd_clk,
   input logic               reset,
   sdc_blk_wr_sched_if.slave bus
);
   localparam logic [ADDR_W-1:0] ADDR_ONE     = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] BLK_STEP     = ADDR_W'(WORDS_PER_BLK);
   localparam logic [ADDR_W-1:0] BLK_LAST_OFS = ADDR_W'(WORDS_PER_BLK - 1);

   sched_state_e      state;
   logic [15:0]       blk_cnt_q;
   logic [ADDR_W-1:0] blk_base;
   logic [ADDR_W-1:0] blk_last;
   logic [1:0]        hold_cnt;
   logic [7:0]        gap_cnt;
   logic              busy_rose, no_busy, busy_cleared, timeout;

   assign blk_last = blk_base + BLK_LAST_OFS;

   sdc_wr_busy_mon #(
      .BUSY_RISE_WIN (BUSY_RISE_WIN)
`ifdef SDC_WR_BUSY_TIMEOUT_EN
      , .BUSY_TO     (BUSY_TO)
`endif
   ) u_busy_mon (
      .sd_clk       (sd_clk),
      .reset        (reset),
      .rise_en      (state == BUSY_RISE),
      .clr_en       (state == BUSY_CLR),
      .wr_busy      (bus.wr_busy),
      .busy_rose    (busy_rose),
      .no_busy      (no_busy),
      .busy_cleared (busy_cleared),
      .timeout      (timeout)
   );

   // NOTE: every state/output register here uses <= so all updates in a cycle see the
   // pre-edge values; a blocking = would make later statements read the new value.
   always_ff @(posedge sd_clk) begin
      if (reset) begin
         state                  <= IDLE;
         blk_cnt_q              <= 16'd0;
         blk_base               <= '0;
         hold_cnt               <= 2'd0;
         gap_cnt                <= 8'd0;
         bus.sm_rd_addr         <= '0;
         bus.sm_rd_en           <= 1'b0;
         bus.strt_snd_data_strb <= 1'b0;
         bus.sched_busy         <= 1'b0;
         bus.done_strb          <= 1'b0;
         bus.blks_done          <= 16'd0;
         bus.err_no_busy        <= 1'b0;
         bus.err_timeout        <= 1'b0;
         bus.aborted            <= 1'b0;
      end else begin
         bus.strt_snd_data_strb <= 1'b0;
         bus.done_strb          <= 1'b0;
         unique case (state)
            IDLE: if (bus.wr_req) begin
               blk_cnt_q       <= bus.blk_cnt;
               blk_base        <= bus.base_addr;
               bus.blks_done   <= 16'd0;
               bus.err_no_busy <= 1'b0;
               bus.err_timeout <= 1'b0;
               bus.aborted     <= 1'b0;
               if (bus.blk_cnt == 16'd0) begin
                  bus.done_strb <= 1'b1;
               end else begin
                  state          <= PREP;
                  bus.sched_busy <= 1'b1;
                  bus.sm_rd_addr <= bus.base_addr;
                  bus.sm_rd_en   <= 1'b1;
               end
            end
            PREP: begin
               state                  <= START;
               bus.strt_snd_data_strb <= 1'b1;
               hold_cnt               <= 2'd0;
            end
            // Word 0 stays put through the sender's sampling point before word 1 appears.
            START: if (hold_cnt == 2'(SND_DAT_SAMPLE_LAT + 1)) begin
               bus.sm_rd_addr <= bus.sm_rd_addr + ADDR_ONE;
               state          <= XFER;
            end else begin
               hold_cnt <= hold_cnt + 2'd1;
            end
            XFER: if (bus.dat_tf_done) begin
               bus.sm_rd_en <= 1'b0;
               state        <= BUSY_RISE;
            end else if (bus.new_dat_strb && bus.sm_rd_addr != blk_last) begin
               bus.sm_rd_addr <= bus.sm_rd_addr + ADDR_ONE;
            end
            BUSY_RISE: if (busy_rose) begin
               state <= BUSY_CLR;
            end else if (no_busy) begin
               bus.err_no_busy <= 1'b1;
               bus.blks_done   <= bus.blks_done + 16'd1;
               blk_base        <= blk_base + BLK_STEP;
               gap_cnt         <= 8'd0;
               state           <= GAP;
            end
            BUSY_CLR: if (busy_cleared) begin
               bus.blks_done <= bus.blks_done + 16'd1;
               blk_base      <= blk_base + BLK_STEP;
               gap_cnt       <= 8'd0;
               state         <= GAP;
            end else if (timeout) begin
               bus.err_timeout <= 1'b1;
               bus.sched_busy  <= 1'b0;
               bus.done_strb   <= 1'b1;
               state           <= IDLE;
            end
            // abort is only honoured here, so a block already handed to the sender always completes.
            GAP: if (gap_cnt == 8'(GAP_CLKS - 1)) begin
               if (bus.blks_done == blk_cnt_q || bus.abort) begin
                  bus.aborted    <= bus.aborted | (bus.blks_done != blk_cnt_q);
                  bus.sched_busy <= 1'b0;
                  bus.done_strb  <= 1'b1;
                  state          <= IDLE;
               end else begin
                  bus.sm_rd_addr <= blk_base;
                  bus.sm_rd_en   <= 1'b1;
                  state          <= PREP;
               end
            end else begin
               gap_cnt <= gap_cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdc_blk_wr_sched.sv
// Directed bench for sdc_blk_wr_sched: request table plus hand-written reset and timeout sequences.
module tb_sdc_blk_wr_sched;
   logic sd_clk = 1'b0;
   logic reset  = 1'b1;
   always #5 sd_clk = ~sd_clk;

   sdc_blk_wr_sched_if #(.ADDR_W(12)) bus ();

   sdc_blk_wr_sched #(
      .ADDR_W        (12),
      .WORDS_PER_BLK (64),
      .GAP_CLKS      (8),
      .BUSY_RISE_WIN (4)
`ifdef SDC_WR_BUSY_TIMEOUT_EN
      , .BUSY_TO     (24'd100)
`endif
   ) dut (
      .sd_clk (sd_clk),
      .reset  (reset),
      .bus    (bus)
   );

   int checks    = 0;
   int errors    = 0;
   int strt_cnt  = 0;
   int done_cnt  = 0;

   always @(negedge sd_clk) begin
      if (bus.strt_snd_data_strb) strt_cnt++;
      if (bus.done_strb) done_cnt++;
   end

   typedef struct {
      int         cnt;
      logic [11:0] base;
      logic [3:0] nobusy_mask;
      int         abort_blk;
      bit         poke;
      int         exp_blks;
      bit         exp_aborted;
      bit         exp_nobusy;
      int         exp_strt;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge sd_clk);
      #1;
   endtask

   // Entered in the PREP cycle; leaves in the last GAP cycle (or just after a timeout).
   task automatic xfer_block(input logic [11:0] base, input int busy_mode, input int exp_done,
                             input bit set_abort, input bit poke);
      logic [11:0] a;
      check("prep_en", bus.sm_rd_en, 1);
      check("prep_addr", bus.sm_rd_addr, base);
      check("prep_no_strt", bus.strt_snd_data_strb, 0);
      tick();
      check("strt_pulse", bus.strt_snd_data_strb, 1);
      check("strt_addr", bus.sm_rd_addr, base);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("w0_hold", {bus.strt_snd_data_strb, bus.sm_rd_addr}, {1'b0, base});
      end
      tick();
      a = base + 12'd1;
      check("w1_addr", bus.sm_rd_addr, a);
      bus.new_dat_strb = 1'b1;
      for (int i = 2; i <= 65; i++) begin
         if (poke && i == 10) begin
            bus.wr_req    = 1'b1;
            bus.blk_cnt   = 16'd9;
            bus.base_addr = 12'h800;
         end
         if (set_abort && i == 32) bus.abort = 1'b1;
         tick();
         bus.wr_req = 1'b0;
         a = (i > 63) ? base + 12'd63 : base + 12'(i);
         check("xfer_addr", bus.sm_rd_addr, a);
      end
      bus.new_dat_strb = 1'b0;
      bus.dat_tf_done  = 1'b1;
      tick();
      bus.dat_tf_done = 1'b0;
      check("rd_en_low_after_done", bus.sm_rd_en, 0);
      case (busy_mode)
         0: begin
            bus.wr_busy = 1'b1;
            tick();
            tick();
            bus.wr_busy = 1'b0;
            tick();
            check("blks_done_inc", bus.blks_done, exp_done);
         end
         1: begin
            repeat (3) tick();
            check("no_busy_early", bus.err_no_busy, 0);
            tick();
            check("no_busy_set", bus.err_no_busy, 1);
            check("blks_done_nobusy", bus.blks_done, exp_done);
         end
         default: begin
            bus.wr_busy = 1'b1;
            tick();
            repeat (99) tick();
            check("timeout_early", bus.err_timeout, 0);
            tick();
            check("timeout_set", bus.err_timeout, 1);
            check("timeout_done", bus.done_strb, 1);
            check("timeout_blks", bus.blks_done, exp_done);
            check("timeout_idle", bus.sched_busy, 0);
            bus.wr_busy = 1'b0;
            return;
         end
      endcase
      for (int g = 1; g <= 7; g++) begin
         tick();
         check("gap_quiet", {bus.strt_snd_data_strb, bus.sm_rd_en}, 0);
      end
   endtask

   task automatic run_req(input vec_t v);
      int s0, d0;
      s0 = strt_cnt;
      d0 = done_cnt;
      bus.blk_cnt   = 16'(v.cnt);
      bus.base_addr = v.base;
      bus.wr_req    = 1'b1;
      tick();
      bus.wr_req = 1'b0;
      if (v.cnt == 0) begin
         check("zero_done", bus.done_strb, 1);
         check("zero_rd_en", bus.sm_rd_en, 0);
         check("zero_busy", bus.sched_busy, 0);
      end else begin
         check("req_busy", bus.sched_busy, 1);
         check("req_clear", {bus.blks_done, bus.aborted, bus.err_no_busy}, 0);
         for (int b = 0; b < v.exp_blks; b++) begin
            xfer_block(v.base + 12'(64 * b), v.nobusy_mask[b] ? 1 : 0, b + 1,
                       v.abort_blk == b + 1, v.poke && b == 0);
            tick();
         end
         check("end_done", bus.done_strb, 1);
         check("end_busy", bus.sched_busy, 0);
         check("end_blks", bus.blks_done, v.exp_blks);
         check("end_aborted", bus.aborted, v.exp_aborted);
         check("end_no_busy", bus.err_no_busy, v.exp_nobusy);
         check("end_timeout", bus.err_timeout, 0);
      end
      bus.abort = 1'b0;
      tick();
      check("done_one_cycle", bus.done_strb, 0);
      repeat (3) tick();
      check("strt_count", strt_cnt - s0, v.exp_strt);
      check("done_count", done_cnt - d0, 1);
   endtask

   initial begin
      vecs[0] = '{cnt: 1, base: 12'h040, nobusy_mask: 4'b0000, abort_blk: 0, poke: 0,
                  exp_blks: 1, exp_aborted: 0, exp_nobusy: 0, exp_strt: 1};
      vecs[1] = '{cnt: 3, base: 12'hFC0, nobusy_mask: 4'b0000, abort_blk: 0, poke: 1,
                  exp_blks: 3, exp_aborted: 0, exp_nobusy: 0, exp_strt: 3};
      vecs[2] = '{cnt: 0, base: 12'h123, nobusy_mask: 4'b0000, abort_blk: 0, poke: 0,
                  exp_blks: 0, exp_aborted: 0, exp_nobusy: 0, exp_strt: 0};
      vecs[3] = '{cnt: 4, base: 12'h100, nobusy_mask: 4'b0000, abort_blk: 2, poke: 0,
                  exp_blks: 2, exp_aborted: 1, exp_nobusy: 0, exp_strt: 2};
      vecs[4] = '{cnt: 2, base: 12'h200, nobusy_mask: 4'b0001, abort_blk: 0, poke: 0,
                  exp_blks: 2, exp_aborted: 0, exp_nobusy: 1, exp_strt: 2};

      bus.wr_req       = 1'b0;
      bus.blk_cnt      = 16'd0;
      bus.base_addr    = 12'd0;
      bus.abort        = 1'b0;
      bus.new_dat_strb = 1'b0;
      bus.dat_tf_done  = 1'b0;
      bus.wr_busy      = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("rst_addr", bus.sm_rd_addr, 0);
      check("rst_ctrl", {bus.sm_rd_en, bus.strt_snd_data_strb, bus.sched_busy, bus.done_strb}, 0);
      check("rst_status", {bus.blks_done, bus.err_no_busy, bus.err_timeout, bus.aborted}, 0);

      for (int n = 0; n < 5; n++) run_req(vecs[n]);

      // Reset in the middle of a block: everything returns to zero with no done pulse.
      begin
         int d0;
         d0 = done_cnt;
         bus.blk_cnt   = 16'd2;
         bus.base_addr = 12'h300;
         bus.wr_req    = 1'b1;
         tick();
         bus.wr_req = 1'b0;
         check("rr_flags_cleared", bus.err_no_busy, 0);
         repeat (5) tick();
         bus.new_dat_strb = 1'b1;
         repeat (5) tick();
         check("rr_mid_addr", bus.sm_rd_addr, 12'h306);
         reset = 1'b1;
         tick();
         reset = 1'b0;
         bus.new_dat_strb = 1'b0;
         check("rr_addr", bus.sm_rd_addr, 0);
         check("rr_ctrl", {bus.sm_rd_en, bus.strt_snd_data_strb, bus.sched_busy, bus.done_strb}, 0);
         check("rr_status", {bus.blks_done, bus.err_no_busy, bus.err_timeout, bus.aborted}, 0);
         repeat (3) tick();
         check("rr_no_done", done_cnt - d0, 0);
         check("rr_idle", {bus.sched_busy, bus.sm_rd_en}, 0);
      end

`ifdef SDC_WR_BUSY_TIMEOUT_EN
      bus.blk_cnt   = 16'd2;
      bus.base_addr = 12'h500;
      bus.wr_req    = 1'b1;
      tick();
      bus.wr_req = 1'b0;
      xfer_block(12'h500, 2, 0, 1'b0, 1'b0);
      tick();
      check("to_done_once", bus.done_strb, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
